// File: rtl/rfPhoenixPkg.sv
// rfPhoenixPkg: shared types and constants for the multi-cycle ALU scheduler.
package rfPhoenixPkg;

  localparam int unsigned VALUE_W     = 32;
  localparam int unsigned INSN_W      = 32;
  localparam int unsigned MCALU_TAG_W = 4;

  typedef logic [VALUE_W-1:0]     Value;
  typedef logic [INSN_W-1:0]      Instruction;
  typedef logic [MCALU_TAG_W-1:0] McAluTag;

  // One buffered ALU result: requester tag plus the result value.
  typedef struct packed {
    McAluTag rid;
    Value    val;
  } McAluResult;

  // Opcode-NOP encoding presented to the ALU in cycles with no issue.
  localparam Instruction MCALU_NOP = Instruction'(32'h0000_007F);

endpackage

// File: rtl/rf_phoenix_mc_alu_resq.sv
// rf_phoenix_mc_alu_resq: synchronous result FIFO with a registered head.
// Push and pop may coincide at any occupancy; a push into an empty queue
// becomes visible at the head on the following cycle (no bypass).
module rf_phoenix_mc_alu_resq
  import rfPhoenixPkg::*;
#(
  parameter int unsigned DEPTH = 8
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  McAluResult i_data,
  input  logic       i_pop,
  output logic       o_valid,
  output McAluResult o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  McAluResult    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_pop;

  // Pointer advance with wrap for non-power-of-two depths.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_valid = (r_cnt != '0);
  assign o_head  = r_mem[r_rd];

  // Storage write; contents need no reset since occupancy gates validity.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_wr <= wrap_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= wrap_inc(r_rd);
      end
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rf_phoenix_mc_alu_sched.sv
// rf_phoenix_mc_alu_sched: issue scheduler and credit-protected result buffer
// for the shared non-stallable multi-cycle ALU.
// Optional feature macro: RFPHOENIX_MCALU_SCHED_RR_EN selects round-robin
// arbitration with a registered pointer; otherwise fixed priority (index 0).
module rf_phoenix_mc_alu_sched
  import rfPhoenixPkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 7,
  parameter int unsigned DEPTH = 8
)
(
  input  logic            rst,
  input  logic            clk,
  input  logic [NREQ-1:0] req,
  input  Instruction      req_ir  [NREQ],
  input  Value            req_a   [NREQ],
  input  Value            req_b   [NREQ],
  input  Value            req_c   [NREQ],
  input  Value            req_imm [NREQ],
  output logic [NREQ-1:0] gnt,
  output Instruction      alu_ir,
  output Value            alu_a,
  output Value            alu_b,
  output Value            alu_c,
  output Value            alu_imm,
  output McAluTag         alu_ridi,
  input  Value            alu_o,
  input  McAluTag         alu_rido,
  output logic            res_valid,
  output McAluTag         res_rid,
  output Value            res_o,
  input  logic            res_ack,
  output logic            busy,
  output logic            rid_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   r_cred;
  logic            r_v0;
  logic [LAT:1]    r_vpipe;
  McAluTag         r_rpipe [LAT:1];
  logic            r_rid_err;

  logic            w_pop;
  logic            w_can_issue;
  logic            w_issue;
  logic            w_found;
  McAluTag         w_off;
  McAluTag         w_win;
  logic [NREQ-1:0] w_req_rot;
  Instruction      w_ir;
  Value            w_a;
  Value            w_b;
  Value            w_c;
  Value            w_imm;
  McAluResult      w_push_data;
  McAluResult      w_head;

`ifdef RFPHOENIX_MCALU_SCHED_RR_EN
  McAluTag         r_ptr;
  logic [4:0]      w_sum;

  // Rotate requests so the search starts at the round-robin pointer.
  assign w_req_rot = NREQ'({req, req} >> r_ptr);

  // Map the rotated offset back to an absolute requester index.
  always_comb begin
    w_sum = 5'(r_ptr) + 5'(w_off);
    w_win = (w_sum >= 5'(NREQ)) ? McAluTag'(w_sum - 5'(NREQ)) : McAluTag'(w_sum);
  end

  // Next search starts just after the last winner; held when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= (w_win == McAluTag'(NREQ - 1)) ? '0 : w_win + McAluTag'(1);
    end
  end
`else
  assign w_req_rot = req;
  assign w_win     = w_off;
`endif

  // Lowest asserted bit of the (possibly rotated) request vector wins.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_found = 1'b1;
        w_off   = McAluTag'(k);
      end
    end
  end

  // A pop in the same cycle frees the credit the new issue needs.
  assign w_pop       = res_ack && res_valid;
  assign w_can_issue = (r_cred < CW'(DEPTH)) || w_pop;
  assign w_issue     = w_found && w_can_issue;
  assign gnt         = w_issue ? (NREQ'(1) << w_win) : '0;

  // Select the granted requester's payload.
  always_comb begin
    w_ir  = MCALU_NOP;
    w_a   = '0;
    w_b   = '0;
    w_c   = '0;
    w_imm = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (gnt[k]) begin
        w_ir  = req_ir[k];
        w_a   = req_a[k];
        w_b   = req_b[k];
        w_c   = req_c[k];
        w_imm = req_imm[k];
      end
    end
  end

  // Issue register: operands hold when idle, instruction drops to NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0     <= 1'b0;
      alu_ir   <= MCALU_NOP;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_c    <= '0;
      alu_imm  <= '0;
      alu_ridi <= '0;
    end else begin
      r_v0 <= w_issue;
      if (w_issue) begin
        alu_ir   <= w_ir;
        alu_a    <= w_a;
        alu_b    <= w_b;
        alu_c    <= w_c;
        alu_imm  <= w_imm;
        alu_ridi <= w_win;
      end else begin
        alu_ir <= MCALU_NOP;
      end
    end
  end

  // In-flight valid and expected-rid pipelines, aligned with the ALU latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe <= '0;
      for (int k = 1; k <= int'(LAT); k++) begin
        r_rpipe[k] <= '0;
      end
    end else begin
      r_vpipe[1] <= r_v0;
      r_rpipe[1] <= alu_ridi;
      for (int k = 2; k <= int'(LAT); k++) begin
        r_vpipe[k] <= r_vpipe[k-1];
        r_rpipe[k] <= r_rpipe[k-1];
      end
    end
  end

  // Credits count in-flight plus buffered operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cred <= '0;
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_cred <= r_cred + CW'(1);
        2'b01:   r_cred <= r_cred - CW'(1);
        default: r_cred <= r_cred;
      endcase
    end
  end

  // Sticky flag for a returning tag that disagrees with the issued one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rid_err <= 1'b0;
    end else if (r_vpipe[LAT] && (alu_rido != r_rpipe[LAT])) begin
      r_rid_err <= 1'b1;
    end
  end

  assign w_push_data = '{rid: alu_rido, val: alu_o};

  rf_phoenix_mc_alu_resq #(
    .DEPTH (DEPTH)
  ) u_resq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_vpipe[LAT]),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (res_valid),
    .o_head  (w_head)
  );

  assign res_rid = w_head.rid;
  assign res_o   = w_head.val;
  assign busy    = (r_cred != '0);
  assign rid_err = r_rid_err;

endmodule

// File: tb/tb_rf_phoenix_mc_alu_sched.sv
// Testbench for rf_phoenix_mc_alu_sched with a behavioural fixed-latency ALU.
module tb_rf_phoenix_mc_alu_sched;
  import rfPhoenixPkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned LAT   = 7;
  localparam int unsigned DEPTH = 8;
  localparam Instruction  FADD  = 32'h0000_0021;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  Instruction      req_ir  [NREQ];
  Value            req_a   [NREQ];
  Value            req_b   [NREQ];
  Value            req_c   [NREQ];
  Value            req_imm [NREQ];
  logic [NREQ-1:0] gnt;
  Instruction      alu_ir;
  Value            alu_a;
  Value            alu_b;
  Value            alu_c;
  Value            alu_imm;
  McAluTag         alu_ridi;
  Value            alu_o;
  McAluTag         alu_rido;
  logic            res_valid;
  McAluTag         res_rid;
  Value            res_o;
  logic            res_ack;
  logic            busy;
  logic            rid_err;
  logic            corrupt;

  int n_chk  = 0;
  int n_pass = 0;

  rf_phoenix_mc_alu_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .rst(rst), .clk(clk), .req(req), .req_ir(req_ir), .req_a(req_a),
    .req_b(req_b), .req_c(req_c), .req_imm(req_imm), .gnt(gnt),
    .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_imm(alu_imm), .alu_ridi(alu_ridi), .alu_o(alu_o), .alu_rido(alu_rido),
    .res_valid(res_valid), .res_rid(res_rid), .res_o(res_o), .res_ack(res_ack),
    .busy(busy), .rid_err(rid_err)
  );

  always #5 clk = ~clk;

  // ALU model: fixed LAT-cycle pipeline; FADD 1.0+2.0 returns 3.0, else a+b+c+imm.
  function automatic Value alu_f(input Value a, input Value b, input Value c, input Value imm);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b + c + imm;
  endfunction

  McAluTag m_rp [LAT];
  Value    m_op [LAT];

  always @(posedge clk) begin
    m_rp[0] <= alu_ridi;
    m_op[0] <= alu_f(alu_a, alu_b, alu_c, alu_imm);
    for (int k = 1; k < int'(LAT); k++) begin
      m_rp[k] <= m_rp[k-1];
      m_op[k] <= m_op[k-1];
    end
  end

  assign alu_rido = m_rp[LAT-1] ^ {corrupt, 3'b000};
  assign alu_o    = m_op[LAT-1];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; res_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Return to idle with a bounded wait.
  task automatic drain();
    logic done;
    done = 1'b0; req = '0; res_ack = 1'b1; corrupt = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick(); #1;
      if (busy === 1'b0) done = 1'b1;
    end
    res_ack = 1'b0;
    n_chk++; if (!done) $display("FAIL drain_timeout: busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    n_chk++; if (gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", res_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (rid_err !== 1'b0) $display("FAIL rst_rid_err: got %b want 0", rid_err); else n_pass++;
    n_chk++; if (alu_ridi !== 4'h0) $display("FAIL rst_alu_ridi: got %h want 0", alu_ridi); else n_pass++;
    n_chk++; if (alu_ir !== MCALU_NOP) $display("FAIL rst_alu_ir: got %h want %h", alu_ir, MCALU_NOP); else n_pass++;
    n_chk++; if (alu_a !== 32'h0) $display("FAIL rst_alu_a: got %h want 0", alu_a); else n_pass++;
    n_chk++; if (alu_imm !== 32'h0) $display("FAIL rst_alu_imm: got %h want 0", alu_imm); else n_pass++;
  endtask

  task automatic test_single();
    tick();
    req_ir[2] = FADD; req_a[2] = 32'h3F80_0000; req_b[2] = 32'h4000_0000;
    req_c[2] = '0; req_imm[2] = '0; res_ack = 1'b0; req = 4'b0100; #1;
    n_chk++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt); else n_pass++;
    tick(); req = '0; #1;
    n_chk++; if (alu_ridi !== 4'h2) $display("FAIL single_ridi: got %h want 2", alu_ridi); else n_pass++;
    n_chk++; if (alu_ir !== FADD) $display("FAIL single_alu_ir: got %h want %h", alu_ir, FADD); else n_pass++;
    n_chk++; if (alu_a !== 32'h3F80_0000) $display("FAIL single_alu_a: got %h want 3f800000", alu_a); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    for (int c = 2; c <= 8; c++) begin
      tick(); #1;
      if (c == 2) begin
        n_chk++; if (alu_ir !== MCALU_NOP) $display("FAIL single_nop: got %h want %h", alu_ir, MCALU_NOP); else n_pass++;
      end
      n_chk++; if (res_valid !== 1'b0) $display("FAIL single_early c=%0d: got %b want 0", c, res_valid); else n_pass++;
    end
    tick(); #1;
    n_chk++; if (res_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", res_valid); else n_pass++;
    n_chk++; if (res_rid !== 4'h2) $display("FAIL single_rid: got %h want 2", res_rid); else n_pass++;
    n_chk++; if (res_o !== 32'h4040_0000) $display("FAIL single_o: got %h want 40400000", res_o); else n_pass++;
    res_ack = 1'b1;
    tick(); res_ack = 1'b0; #1;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL single_pop: got %b want 0", res_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_all_four();
    int unsigned q[$];
    logic [NREQ-1:0] exp_g;
    int unsigned r;
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ir[i] = FADD; req_a[i] = 32'h1000 * (i + 1); req_b[i] = Value'(i);
      req_c[i] = '0; req_imm[i] = '0;
    end
    tick(); res_ack = 1'b1; req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      #1;
`ifdef RFPHOENIX_MCALU_SCHED_RR_EN
      exp_g = 4'b0001 << (c % 4);
      q.push_back(c % 4);
`else
      exp_g = 4'b0001;
      q.push_back(0);
`endif
      n_chk++; if (gnt !== exp_g) $display("FAIL all4_gnt c=%0d: got %b want %b", c, gnt, exp_g); else n_pass++;
    end
    tick(); req = '0;
    for (int c = 0; c < 24 && q.size() > 0; c++) begin
      #1;
      if (res_valid === 1'b1) begin
        r = q.pop_front();
        n_chk++; if (res_rid !== McAluTag'(r)) $display("FAIL all4_rid: got %h want %h", res_rid, r); else n_pass++;
        n_chk++; if (res_o !== 32'h1000 * (r + 1) + r) $display("FAIL all4_o: got %h want %h", res_o, 32'h1000 * (r + 1) + r); else n_pass++;
      end
      tick();
    end
    n_chk++; if (q.size() != 0) $display("FAIL all4_timeout: got %0d pending want 0", q.size()); else n_pass++;
    n_chk++; if (rid_err !== 1'b0) $display("FAIL all4_rid_err: got %b want 0", rid_err); else n_pass++;
    drain();
  endtask

  task automatic test_arbitration();
    logic [NREQ-1:0] exp_g;
    do_reset();
    tick(); res_ack = 1'b0; req = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #1;
`ifdef RFPHOENIX_MCALU_SCHED_RR_EN
      exp_g = (c >= 8) ? 4'b0000 : ((c % 2 == 0) ? 4'b0010 : 4'b1000);
`else
      exp_g = (c >= 8) ? 4'b0000 : 4'b0010;
`endif
      n_chk++; if (gnt !== exp_g) $display("FAIL arb_gnt c=%0d: got %b want %b", c, gnt, exp_g); else n_pass++;
    end
    drain();
  endtask

  task automatic test_back_pressure();
    int ngr;
    ngr = 0;
    tick(); res_ack = 1'b0; req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      #1;
      if (gnt[0] === 1'b1) ngr++;
    end
    n_chk++; if (ngr != 8) $display("FAIL bp_grants: got %0d want 8", ngr); else n_pass++;
    n_chk++; if (gnt !== 4'b0000) $display("FAIL bp_stall: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (res_valid !== 1'b1) $display("FAIL bp_head: got %b want 1", res_valid); else n_pass++;
    tick(); res_ack = 1'b1; #1;
    n_chk++; if (gnt !== 4'b0001) $display("FAIL bp_pulse_gnt: got %b want 0001", gnt); else n_pass++;
    ngr = 0;
    for (int c = 0; c < 5; c++) begin
      tick(); res_ack = 1'b0; #1;
      if (gnt[0] === 1'b1) ngr++;
    end
    n_chk++; if (ngr != 0) $display("FAIL bp_after_pulse: got %0d want 0", ngr); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    logic seen;
    tick(); res_ack = 1'b1; req = 4'b0001;
    for (int c = 1; c <= 3; c++) tick();
    tick(); rst = 1'b1; req = '0;
    tick(); rst = 1'b0; #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", res_valid); else n_pass++;
    seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick(); #1;
      if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL rmid_ghost: got %b want 0", seen); else n_pass++;
    tick(); req = 4'b0010; #1;
    n_chk++; if (gnt !== 4'b0010) $display("FAIL rmid_gnt: got %b want 0010", gnt); else n_pass++;
    for (int c = 1; c <= 8; c++) begin
      tick(); req = '0; #1;
    end
    n_chk++; if (res_valid !== 1'b0) $display("FAIL rmid_early: got %b want 0", res_valid); else n_pass++;
    tick(); #1;
    n_chk++; if (res_valid !== 1'b1) $display("FAIL rmid_valid9: got %b want 1", res_valid); else n_pass++;
    n_chk++; if (res_rid !== 4'h1) $display("FAIL rmid_rid: got %h want 1", res_rid); else n_pass++;
    n_chk++; if (res_o !== 32'h0000_2001) $display("FAIL rmid_o: got %h want 00002001", res_o); else n_pass++;
    drain();
  endtask

  task automatic test_rid_err();
    tick(); res_ack = 1'b0; corrupt = 1'b1; req = 4'b1000; #1;
    n_chk++; if (gnt !== 4'b1000) $display("FAIL riderr_gnt: got %b want 1000", gnt); else n_pass++;
    for (int c = 1; c <= 8; c++) begin
      tick(); req = '0; #1;
    end
    n_chk++; if (rid_err !== 1'b0) $display("FAIL riderr_pre: got %b want 0", rid_err); else n_pass++;
    tick(); #1;
    n_chk++; if (rid_err !== 1'b1) $display("FAIL riderr_rise: got %b want 1", rid_err); else n_pass++;
    n_chk++; if (res_valid !== 1'b1) $display("FAIL riderr_valid: got %b want 1", res_valid); else n_pass++;
    n_chk++; if (res_rid !== 4'hB) $display("FAIL riderr_rid: got %h want b", res_rid); else n_pass++;
    n_chk++; if (res_o !== 32'h0000_4003) $display("FAIL riderr_o: got %h want 00004003", res_o); else n_pass++;
    drain();
    n_chk++; if (rid_err !== 1'b1) $display("FAIL riderr_sticky1: got %b want 1", rid_err); else n_pass++;
    tick(); req = 4'b0001;
    tick(); req = '0;
    drain();
    n_chk++; if (rid_err !== 1'b1) $display("FAIL riderr_sticky2: got %b want 1", rid_err); else n_pass++;
    do_reset(); #1;
    n_chk++; if (rid_err !== 1'b0) $display("FAIL riderr_clear: got %b want 0", rid_err); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; req = '0; res_ack = 1'b0; corrupt = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ir[i] = FADD; req_a[i] = '0; req_b[i] = '0; req_c[i] = '0; req_imm[i] = '0;
    end
    test_reset();
    test_single();
    test_all_four();
    test_arbitration();
    test_back_pressure();
    test_reset_mid();
    test_rid_err();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_phoenix_mc_alu_sched.md
# rf_phoenix_mc_alu_sched

Issue scheduler and result buffer for the shared multi-cycle ALU (FMA/FADD/FMUL, I2F/F2I, FTRUNC, reciprocal estimates, MULI). The block sits between the per-thread operand-read stages and the single non-stallable ALU pipeline:
- Arbitrates among NREQ requesters and registers the winner's operands into the ALU.
- Tags each operation with its requester id on `ridi`.
- Tracks in-flight slots with a valid shift register.
- Captures each result into a credit-protected FIFO so writeback can back-pressure without stalling the ALU.

## Interface
Parameters:
- NREQ, 4 — number of requesters (1..16); the requester index is carried as the 4-bit rid.
- LAT, 7 — fixed ALU latency from operands registered to `o`/`rido` valid; must match the ALU `rido` delay.
- DEPTH, 8 — result FIFO entries; DEPTH ≥ 2. In-flight plus buffered operations are limited to DEPTH.

Ports:
- rst  in  1  — reset; synchronous, active-high.
- clk  in  1  — the single clock; all state changes on the rising edge.
- req  in  NREQ  — per-requester operation request.
- req_ir  in  NREQ×Instruction  — per-requester instruction.
- req_a, req_b, req_c, req_imm  in  NREQ×Value each  — per-requester operands.
- gnt  out  NREQ  — one-hot grant, combinational; the request is consumed in the cycle `req[i]&gnt[i]`.
- alu_ir  out  Instruction  — registered instruction to the ALU.
- alu_a, alu_b, alu_c, alu_imm  out  Value each  — registered operands to the ALU.
- alu_ridi  out  4  — registered rid (winner index) to the ALU.
- alu_o  in  Value  — ALU result.
- alu_rido  in  4  — ALU-delayed rid.
- res_valid  out  1  — FIFO head valid.
- res_rid  out  4  — FIFO head rid.
- res_o  out  Value  — FIFO head result.
- res_ack  in  1  — consumer pops the head; ignored when `res_valid`=0.
- busy  out  1  — any operation in flight or buffered.
- rid_err  out  1  — sticky: `alu_rido` ≠ expected rid at capture.

## Operation
- Credit counter `cred` runs 0..DEPTH and counts in-flight plus buffered operations.
- `cred` increments on issue and decrements on pop; on simultaneous issue and pop it is unchanged.
- Issue is allowed when `cred < DEPTH` or `res_ack & res_valid` in the same cycle.
- Arbitration: with RR_EN, round-robin; otherwise fixed priority, lowest index wins.
- `gnt` is all-zero when issue is not allowed or no `req` is asserted.
- Issue register: on issue, capture the winner's ir, a, b, c, imm and rid, and set `v0`=1.
- When not issuing, `v0`=0 and `alu_ir` is forced to an opcode-NOP encoding; operands hold their previous values.
- Valid pipeline: `vpipe[LAT:1]` shifts `v0` along with a parallel rid pipeline `rpipe`.
- Capture: when `vpipe[LAT]`=1, push `{alu_rido, alu_o}` into the FIFO.
- At capture, compare `alu_rido` with `rpipe[LAT]`; on mismatch set `rid_err`. `rid_err` clears only on rst.
- FIFO: simultaneous push and pop is allowed at any occupancy, including empty→push/pop. When empty, the pushed entry appears at the head the next cycle; there is no bypass.
- FIFO overflow cannot occur because of the credit rule.
- `busy` = `(cred != 0)`.
- Reset mid-operation: all in-flight and buffered operations are discarded; late ALU outputs are ignored because `vpipe` is cleared.

Reset values:
- `gnt`, `res_valid`, `busy`, `rid_err`, `alu_ridi` = 0.
- `alu_ir` = NOP.
- `alu_a`, `alu_b`, `alu_c`, `alu_imm` = 0.
- `cred` = 0.
- Round-robin pointer = 0.

## Timing
- Cycle N: `req[i]&gnt[i]`.
- Cycle N+1: `alu_*` and `alu_ridi` valid.
- Cycle N+1+LAT: `alu_o`/`alu_rido` sampled into the FIFO.
- Cycle N+2+LAT: `res_valid` is set. Minimum request-to-result latency is LAT+2 = 9 cycles.
- Throughput: one issue per cycle while credits remain.
- Steady state needs DEPTH ≥ LAT+2 for back-to-back issue with immediate ack; the default DEPTH=8 sustains 8 issues per 9 cycles.
- Round-robin pointer update: after a grant to index i, the next search starts at i+1 mod NREQ. The pointer is unchanged when there is no grant.

## Configuration
- `RFPHOENIX_MCALU_SCHED_RR_EN` defined: round-robin arbitration with a registered pointer.
- Undefined: fixed priority, index 0 highest; no pointer register.

## Structure
Put in rfPhoenixPkg:
- An `McAluTag` typedef (4-bit rid).
- An `McAluResult` struct `{rid, Value}`.
- A `MCALU_NOP` instruction constant.

One sub-module: `rf_phoenix_mc_alu_resq`, a synchronous FIFO of `McAluResult` with parameter DEPTH, push/pop and a registered head. The arbiter and credit logic stay in the top module.

## Test plan
- Single request: req[2]=1 with FADD a=0x3F800000, b=0x40000000 and an ALU model returning 0x40400000. Required: gnt[2] in cycle 0; res_valid with rid=2, res_o=0x40400000 in cycle 9.
- All four requesters held for 8 cycles, res_ack=1 (RR_EN): grants 0,1,2,3,0,1,2,3; results return in the same order; rid_err=0.
- Fixed priority (no macro): req=4'b1010 held → gnt stays 4'b0010 every cycle in which credits allow.
- Back-pressure: res_ack=0 with continuous req[0] → exactly 8 grants, then gnt=0. Pulse res_ack once → exactly one further grant, in that same cycle.
- Reset in cycle 4 of an in-flight burst: no res_valid afterwards, busy=0, cred=0, and a new request completes normally 9 cycles after reissue.
- ALU model corrupts rido on one result → rid_err rises at capture and stays 1 until rst.
